// File: rtl/branch_condition_unit_pkg.sv
// Shared CPU definitions for branch resolution: condition codes, FSM states, flag layout.
package branch_condition_unit_pkg;

  localparam int unsigned PC_W_DEFAULT = 18;
  localparam int unsigned COND_W       = 3;
  localparam int unsigned FLAG_W       = 3;

  // Bit positions inside the {Z,G,L} flag vector
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_G = 1;
  localparam int unsigned FLAG_L = 0;

  localparam logic [COND_W-1:0] COND_BEQ = 3'b000;
  localparam logic [COND_W-1:0] COND_BNE = 3'b001;
  localparam logic [COND_W-1:0] COND_BGT = 3'b010;
  localparam logic [COND_W-1:0] COND_BLT = 3'b011;
  localparam logic [COND_W-1:0] COND_BGE = 3'b100;
  localparam logic [COND_W-1:0] COND_BLE = 3'b101;
  localparam logic [COND_W-1:0] COND_BAL = 3'b110;
  localparam logic [COND_W-1:0] COND_BNV = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // BAL/BNV never look at the flags
  function automatic logic cond_is_flag_indep(input logic [COND_W-1:0] cond);
    return (cond == COND_BAL) || (cond == COND_BNV);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational branch condition evaluation: (cond, Z, G, L) -> take.
module cond_eval
  import branch_condition_unit_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic              z,
  input  logic              g,
  input  logic              l,
  output logic              take_c
);

  // Raw flag bits are used as-is; a non-one-hot result is not masked
  always_comb begin
    take_c = 1'b0;
    unique case (cond)
      COND_BEQ: take_c = z;
      COND_BNE: take_c = ~z;
      COND_BGT: take_c = g;
      COND_BLT: take_c = l;
      COND_BGE: take_c = g | z;
      COND_BLE: take_c = l | z;
      COND_BAL: take_c = 1'b1;
      COND_BNV: take_c = 1'b0;
      default:  take_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_condition_unit.sv
// Captures comparator flags and resolves conditional branches into taken/next_pc,
// stalling flag-dependent branches until a first compare and forwarding same-cycle results.
module branch_condition_unit
  import branch_condition_unit_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmp_valid,
  input  logic              equal,
  input  logic              a_greater,
  input  logic              a_less,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [COND_W-1:0] br_cond,
  input  logic [PC_W-1:0]   br_target,
  input  logic [PC_W-1:0]   pc,
  output logic              res_valid,
  output logic              res_take,
  output logic [PC_W-1:0]   next_pc,
  output logic [FLAG_W-1:0] flags,
  output logic              flag_err
);

  state_e              state;
  state_e              state_nxt;
  logic                flags_valid;
  logic [COND_W-1:0]   hold_cond;
  logic [PC_W-1:0]     hold_target;
  logic [PC_W-1:0]     hold_pc;

  logic [FLAG_W-1:0]   cmp_bits_c;
  logic [FLAG_W-1:0]   eval_flags_c;
  logic [COND_W-1:0]   sel_cond_c;
  logic [PC_W-1:0]     sel_target_c;
  logic [PC_W-1:0]     sel_pc_c;
  logic [PC_W-1:0]     pc_next_c;
  logic                resolve_c;
  logic                latch_c;
  logic                take_c;
  logic                onehot_c;

  assign cmp_bits_c = {equal, a_greater, a_less};
  assign onehot_c   = (cmp_bits_c == 3'b100) || (cmp_bits_c == 3'b010) ||
                      (cmp_bits_c == 3'b001);

  // Forward the live comparator result over the stored flags when both exist
  assign eval_flags_c = cmp_valid ? cmp_bits_c : flags;

  // Held branch fields while stalled, live request fields otherwise
  assign sel_cond_c   = (state == ST_WAIT) ? hold_cond   : br_cond;
  assign sel_target_c = (state == ST_WAIT) ? hold_target : br_target;
  assign sel_pc_c     = (state == ST_WAIT) ? hold_pc     : pc;

  cond_eval u_cond_eval (
    .cond   (sel_cond_c),
    .z      (eval_flags_c[FLAG_Z]),
    .g      (eval_flags_c[FLAG_G]),
    .l      (eval_flags_c[FLAG_L]),
    .take_c (take_c)
  );

  // Fallthrough wraps naturally at the PC width
  assign pc_next_c = take_c ? sel_target_c : PC_W'(sel_pc_c + PC_W'(1));

  // Next-state and resolve/latch decisions
  always_comb begin
    state_nxt = state;
    resolve_c = 1'b0;
    latch_c   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (br_valid) begin
          if (cond_is_flag_indep(br_cond) || flags_valid || cmp_valid) begin
            resolve_c = 1'b1;
          end else begin
            latch_c   = 1'b1;
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cmp_valid) begin
          resolve_c = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; br_ready is registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      br_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      br_ready <= (state_nxt == ST_IDLE);
    end
  end

  // Flag register, sticky until the next compare; error pulse on non-one-hot capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags       <= '0;
      flags_valid <= 1'b0;
      flag_err    <= 1'b0;
    end else begin
      flag_err <= cmp_valid && !onehot_c;
      if (cmp_valid) begin
        flags       <= cmp_bits_c;
        flags_valid <= 1'b1;
      end
    end
  end

  // Hold registers for a branch stalled on missing flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cond   <= '0;
      hold_target <= '0;
      hold_pc     <= '0;
    end else if (latch_c) begin
      hold_cond   <= br_cond;
      hold_target <= br_target;
      hold_pc     <= pc;
    end
  end

  // Decision outputs; take/next_pc hold between results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_take  <= 1'b0;
      next_pc   <= '0;
    end else begin
      res_valid <= resolve_c;
      if (resolve_c) begin
        res_take <= take_c;
        next_pc  <= pc_next_c;
      end
    end
  end

endmodule

// File: tb/tb_branch_condition_unit.sv
// Self-checking bench for branch_condition_unit: directed corner cases, a condition sweep table,
// and randomized traffic against a behavioural model.
module tb_branch_condition_unit;

  localparam int unsigned PC_W = 18;
  localparam logic [PC_W-1:0] PC_MAX = 18'h3FFFF;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmp_valid, equal, a_greater, a_less;
  logic            br_valid;
  logic            br_ready;
  logic [2:0]      br_cond;
  logic [PC_W-1:0] br_target, pc;
  logic            res_valid, res_take;
  logic [PC_W-1:0] next_pc;
  logic [2:0]      flags;
  logic            flag_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state and expected outputs
  logic [2:0]      m_flags;
  logic            m_fv;
  logic            m_wait;
  logic [2:0]      m_hcond;
  logic [PC_W-1:0] m_htgt, m_hpc;
  logic            e_rv, e_take, e_err, e_ready;
  logic [PC_W-1:0] e_npc;

  branch_condition_unit #(.PC_W(PC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmp_valid (cmp_valid),
    .equal     (equal),
    .a_greater (a_greater),
    .a_less    (a_less),
    .br_valid  (br_valid),
    .br_ready  (br_ready),
    .br_cond   (br_cond),
    .br_target (br_target),
    .pc        (pc),
    .res_valid (res_valid),
    .res_take  (res_take),
    .next_pc   (next_pc),
    .flags     (flags),
    .flag_err  (flag_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Condition truth from the architectural definition of each code
  function automatic logic cond_true(input logic [2:0] c, input logic [2:0] f);
    logic z, g, l;
    z = f[2]; g = f[1]; l = f[0];
    case (c)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return g;
      3'd3: return l;
      3'd4: return g || z;
      3'd5: return l || z;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = 3'b000; m_fv = 1'b0; m_wait = 1'b0;
    m_hcond = 3'b000; m_htgt = '0; m_hpc = '0;
    e_rv = 1'b0; e_take = 1'b0; e_npc = '0; e_err = 1'b0; e_ready = 1'b1;
  endtask

  // Advance the model by one clock using the inputs presented before the edge
  task automatic model_step();
    logic [2:0]      bits, ef, c;
    logic [PC_W-1:0] t, p;
    logic            resolve;
    int              ones;
    if (!rst_n) return;
    bits = {equal, a_greater, a_less};
    ef = cmp_valid ? bits : m_flags;
    resolve = 1'b0; c = '0; t = '0; p = '0;
    if (!m_wait) begin
      if (br_valid) begin
        if (br_cond >= 3'd6 || m_fv || cmp_valid) begin
          resolve = 1'b1; c = br_cond; t = br_target; p = pc;
        end else begin
          m_wait = 1'b1; m_hcond = br_cond; m_htgt = br_target; m_hpc = pc;
        end
      end
    end else if (cmp_valid) begin
      resolve = 1'b1; c = m_hcond; t = m_htgt; p = m_hpc; m_wait = 1'b0;
    end
    e_rv = resolve;
    if (resolve) begin
      e_take = cond_true(c, ef);
      e_npc  = e_take ? t : PC_W'((int'(p) + 1) % (1 << PC_W));
    end
    ones = int'(bits[0]) + int'(bits[1]) + int'(bits[2]);
    e_err = cmp_valid && (ones != 1);
    if (cmp_valid) begin
      m_flags = bits; m_fv = 1'b1;
    end
    e_ready = !m_wait;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmp_valid = 0; equal = 0; a_greater = 0; a_less = 0;
    br_valid = 0; br_cond = 0; br_target = '0; pc = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_cmp(input logic [2:0] b);
    cmp_valid = 1; {equal, a_greater, a_less} = b;
  endtask

  task automatic set_br(input logic [2:0] c, input logic [PC_W-1:0] p, input logic [PC_W-1:0] t);
    br_valid = 1; br_cond = c; pc = p; br_target = t;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".res_valid"}, res_valid, e_rv);
    check({tag, ".res_take"},  res_take,  e_take);
    check({tag, ".next_pc"},   next_pc,   e_npc);
    check({tag, ".flags"},     flags,     m_flags);
    check({tag, ".flag_err"},  flag_err,  e_err);
    check({tag, ".br_ready"},  br_ready,  e_ready);
  endtask

  typedef struct {
    logic [2:0]      fl;
    logic [2:0]      cond;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] tgt;
    logic            take;
  } vec_t;

  vec_t vecs[24];

  initial begin
    logic [7:0] takes [3];
    logic [2:0] fls [3];
    logic [7:0] tv;

    // Sweep table: bit i of takes[k] is the expected outcome of code i under fls[k]
    fls[0] = 3'b100; takes[0] = 8'b0111_0001;
    fls[1] = 3'b010; takes[1] = 8'b0101_0110;
    fls[2] = 3'b001; takes[2] = 8'b0110_1010;
    for (int k = 0; k < 3; k++) begin
      tv = takes[k];
      for (int i = 0; i < 8; i++) begin
        vecs[k*8+i].fl   = fls[k];
        vecs[k*8+i].cond = 3'(i);
        vecs[k*8+i].pc   = PC_W'(18'h01000 + k*16 + i);
        vecs[k*8+i].tgt  = PC_W'(18'h20000 + k*256 + i*4);
        vecs[k*8+i].take = tv[i];
      end
    end

    idle_inputs();
    do_reset();

    // Reset state
    check("rst.res_valid", res_valid, 0);
    check("rst.res_take",  res_take,  0);
    check("rst.next_pc",   next_pc,   0);
    check("rst.flags",     flags,     0);
    check("rst.flag_err",  flag_err,  0);
    check("rst.br_ready",  br_ready,  1);

    // Stall then resolve
    set_br(3'd0, 18'h00010, 18'h00100);
    step();
    idle_inputs();
    check("stall.br_ready",  br_ready,  0);
    check("stall.res_valid", res_valid, 0);
    step();
    check("stall.hold_ready", br_ready, 0);
    check("stall.hold_valid", res_valid, 0);
    set_cmp(3'b100);
    step();
    idle_inputs();
    check("stall.res_valid2", res_valid, 1);
    check("stall.res_take",   res_take,  1);
    check("stall.next_pc",    next_pc,   18'h00100);
    check("stall.flags",      flags,     3'b100);
    check("stall.ready_back", br_ready,  1);
    step();
    check("stall.pulse_end",  res_valid, 0);
    check("stall.take_hold",  res_take,  1);
    check("stall.npc_hold",   next_pc,   18'h00100);

    // Same-cycle forwarding: stored G, incoming L drives BLT
    set_cmp(3'b010);
    step();
    idle_inputs();
    check("fwd.flags_g", flags, 3'b010);
    set_br(3'd3, 18'h00200, 18'h00300);
    set_cmp(3'b001);
    step();
    idle_inputs();
    check("fwd.res_valid", res_valid, 1);
    check("fwd.res_take",  res_take,  1);
    check("fwd.next_pc",   next_pc,   18'h00300);
    check("fwd.flags_l",   flags,     3'b001);

    // PC wrap on fallthrough
    set_cmp(3'b100);
    step();
    idle_inputs();
    set_br(3'd1, PC_MAX, 18'h01000);
    step();
    idle_inputs();
    check("wrap.res_valid", res_valid, 1);
    check("wrap.res_take",  res_take,  0);
    check("wrap.next_pc",   next_pc,   0);

    // Full condition sweep, back-to-back within each flag setting
    for (int k = 0; k < 3; k++) begin
      set_cmp(vecs[k*8].fl);
      step();
      idle_inputs();
      for (int i = 0; i < 8; i++) begin
        set_br(vecs[k*8+i].cond, vecs[k*8+i].pc, vecs[k*8+i].tgt);
        step();
        check($sformatf("sweep%0d_%0d.res_valid", k, i), res_valid, 1);
        check($sformatf("sweep%0d_%0d.res_take", k, i), res_take, vecs[k*8+i].take);
        check($sformatf("sweep%0d_%0d.next_pc", k, i), next_pc,
              vecs[k*8+i].take ? vecs[k*8+i].tgt : vecs[k*8+i].pc + 18'd1);
      end
      idle_inputs();
      step();
      check($sformatf("sweep%0d.idle", k), res_valid, 0);
    end

    // Bad comparator result 011
    set_cmp(3'b011);
    step();
    idle_inputs();
    check("bad.flag_err", flag_err, 1);
    check("bad.flags",    flags,    3'b011);
    step();
    check("bad.err_pulse", flag_err, 0);
    set_br(3'd0, 18'h00400, 18'h00500);
    step();
    check("bad.beq_take", res_take, 0);
    check("bad.beq_npc",  next_pc,  18'h00401);
    set_br(3'd2, 18'h00600, 18'h00700);
    step();
    idle_inputs();
    check("bad.bgt_valid", res_valid, 1);
    check("bad.bgt_take",  res_take,  1);
    check("bad.bgt_npc",   next_pc,   18'h00700);

    // Reset mid-WAIT
    do_reset();
    set_br(3'd4, 18'h00800, 18'h00900);
    step();
    idle_inputs();
    check("rw.in_wait", br_ready, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rw.res_valid", res_valid, 0);
    check("rw.res_take",  res_take,  0);
    check("rw.next_pc",   next_pc,   0);
    check("rw.flags",     flags,     0);
    check("rw.br_ready",  br_ready,  1);
    set_cmp(3'b100);
    @(posedge clk);
    #1;
    check("rw.ignored_valid", res_valid, 0);
    check("rw.ignored_flags", flags,     0);
    idle_inputs();
    rst_n = 1'b1;
    step();
    check("rw.no_spurious", res_valid, 0);
    set_br(3'd6, 18'h00A00, 18'h00B00);
    step();
    check("rw.bal_valid", res_valid, 1);
    check("rw.bal_take",  res_take,  1);
    check("rw.bal_npc",   next_pc,   18'h00B00);
    set_br(3'd0, 18'h00C00, 18'h00D00);
    step();
    idle_inputs();
    check("rw.restall_ready", br_ready,  0);
    check("rw.restall_valid", res_valid, 0);
    set_cmp(3'b001);
    step();
    idle_inputs();
    check("rw.resolve_valid", res_valid, 1);
    check("rw.resolve_take",  res_take,  0);
    check("rw.resolve_npc",   next_pc,   18'h00C01);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
        check_model("rnd_rst");
      end
      cmp_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) {equal, a_greater, a_less} = 3'($urandom);
      else {equal, a_greater, a_less} = 3'(1 << $urandom_range(0, 2));
      br_valid  = $urandom_range(0, 1);
      br_cond   = 3'($urandom);
      br_target = PC_W'($urandom);
      pc        = ($urandom_range(0, 7) == 0) ? PC_MAX : PC_W'($urandom);
      step();
      check_model("rnd");
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
